// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - shared WS2812 state encoding and default line timing
package ws2812_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HIGH  = 2'd1,
    S_LOW   = 2'd2,
    S_LATCH = 2'd3
  } ws2812_state_e;

  // Defaults assume a 20 MHz clock: 200 ns / 400 ns highs, 750 ns bit, 30 us latch.
  localparam int WS2812_T0H     = 4;
  localparam int WS2812_T1H     = 8;
  localparam int WS2812_T_BIT   = 15;
  localparam int WS2812_T_RESET = 600;

  function automatic int ws2812_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_transmitter.sv
// rtl/ws2812_transmitter.sv - frame serializer driving a WS2812 LED strip
module ws2812_transmitter
  import ws2812_pkg::*;
#(
  parameter int LEDS        = 32,
  parameter int T0H         = WS2812_T0H,
  parameter int T1H         = WS2812_T1H,
  parameter int T_BIT       = WS2812_T_BIT,
  parameter int T_RESET     = WS2812_T_RESET,
  parameter int FRAME_BYTES = LEDS * 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic [7:0] data,
  output logic       data_request,
  output logic       dout,
  output logic       busy
);

  localparam int TW = $clog2(ws2812_max(T_BIT, T_RESET)) + 1;
  localparam int BW = $clog2(FRAME_BYTES) + 1;

  localparam logic [TW-1:0] T0H_C    = TW'(T0H);
  localparam logic [TW-1:0] T1H_C    = TW'(T1H);
  localparam logic [TW-1:0] T_BIT_C  = TW'(T_BIT);
  localparam logic [TW-1:0] T_RST_C  = TW'(T_RESET);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(FRAME_BYTES - 1);

  if (!(T0H > 0 && T0H < T1H && T1H < T_BIT && T_RESET >= 1 &&
        LEDS >= 1 && FRAME_BYTES >= 1)) begin : g_bad_params
    $error("ws2812_transmitter: illegal timing or size parameters");
  end

  ws2812_state_e state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_q;
  logic [BW-1:0] byte_q;
  logic [TW-1:0] tmr_q;
  logic          dout_q;

  logic [TW-1:0] th;
  logic [TW-1:0] low_len;
  logic          high_last;
  logic          low_last;
  logic          more_bytes;
  logic          accept;
  logic          next_byte;

  // High time follows the bit currently in the MSB; the low time pads it to T_BIT.
  assign th         = shift_q[7] ? T1H_C : T0H_C;
  assign low_len    = T_BIT_C - th;
  assign high_last  = (tmr_q == th - TMR_ONE);
  assign low_last   = (tmr_q == low_len - TMR_ONE);
  assign more_bytes = (byte_q < LAST_BYTE);

  assign accept    = !rst && (state_q == S_IDLE) && trigger;
  assign next_byte = !rst && (state_q == S_LOW) && low_last &&
                     (bit_q == 3'd0) && more_bytes;

  assign data_request = accept || next_byte;
  assign dout         = dout_q;
  assign busy         = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tmr_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            shift_q <= data;
            bit_q   <= 3'd7;
            byte_q  <= '0;
            tmr_q   <= '0;
            dout_q  <= 1'b1;
            state_q <= S_HIGH;
          end
        end

        S_HIGH: begin
          if (high_last) begin
            tmr_q   <= '0;
            dout_q  <= 1'b0;
            state_q <= S_LOW;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end

        S_LOW: begin
          if (!low_last) begin
            tmr_q <= tmr_q + TMR_ONE;
          end else if (bit_q != 3'd0) begin
            shift_q <= {shift_q[6:0], 1'b0};
            bit_q   <= bit_q - 3'd1;
            tmr_q   <= '0;
            dout_q  <= 1'b1;
            state_q <= S_HIGH;
          end else if (more_bytes) begin
            // Reload straight into HIGH so byte boundaries add no idle cycle.
            shift_q <= data;
            bit_q   <= 3'd7;
            byte_q  <= byte_q + BW'(1);
            tmr_q   <= '0;
            dout_q  <= 1'b1;
            state_q <= S_HIGH;
          end else begin
            tmr_q   <= '0;
            state_q <= S_LATCH;
          end
        end

        S_LATCH: begin
          if (tmr_q == T_RST_C - TMR_ONE) begin
            tmr_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            tmr_q <= tmr_q + TMR_ONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          dout_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
